// File: rtl/tensor_dot_sched_if.sv
// Handshake bundle for tensor_dot_sched: request, dot-unit issue/return and
// writeback response channels. slave = scheduler side, master = environment.
interface tensor_dot_sched_if #(
  parameter int NUM_REQS  = 4,
  parameter int MAC_UNITS = 4,
  parameter int LEN_W     = 8,
  parameter int RSP_W     = 32
);
  localparam int ID_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*LEN_W-1:0] req_len;
  logic [NUM_REQS-1:0]       req_ready;

  logic                 dot_valid;
  logic                 dot_ready;
  logic [ID_W-1:0]      dot_id;
  logic [LEN_W-1:0]     dot_offset;
  logic [MAC_UNITS-1:0] dot_mask;
  logic                 dot_last;

  logic             dot_rsp_valid;
  logic [RSP_W-1:0] dot_rsp_data;
  logic [ID_W-1:0]  dot_rsp_id;
  logic             dot_rsp_last;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RSP_W-1:0] rsp_data;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_last;

  modport slave (
    input  req_valid, req_len,
    output req_ready,
    output dot_valid, dot_id, dot_offset, dot_mask, dot_last,
    input  dot_ready,
    input  dot_rsp_valid, dot_rsp_data, dot_rsp_id, dot_rsp_last,
    output rsp_valid, rsp_data, rsp_id, rsp_last,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_len,
    input  req_ready,
    input  dot_valid, dot_id, dot_offset, dot_mask, dot_last,
    output dot_ready,
    output dot_rsp_valid, dot_rsp_data, dot_rsp_id, dot_rsp_last,
    input  rsp_valid, rsp_data, rsp_id, rsp_last,
    output rsp_ready
  );
endinterface

// File: rtl/tensor_dot_sched.sv
// Round-robin dot-product job scheduler with credit-protected response FIFO.
// Optional perf counters: define TENSOR_DOT_SCHED_PERF_EN.
module tensor_dot_sched #(
  parameter int NUM_REQS  = 4,
  parameter int MAC_UNITS = 4,
  parameter int LEN_W     = 8,
  parameter int RSP_W     = 32,
  parameter int RSP_DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  tensor_dot_sched_if.slave bus
`ifdef TENSOR_DOT_SCHED_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_credit_stalls
`endif
);
  localparam int ID_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = LEN_W + 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W:0]   offset;

  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;
  logic            grant;
  logic            issuing;
  logic            credit_ok;
  logic            beat_fire;
  logic            beat_last;
  logic [MAC_UNITS-1:0] beat_mask;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             dec;
  logic             full;

  logic [RSP_W-1:0] mem_data [RSP_DEPTH];
  logic [ID_W-1:0]  mem_id   [RSP_DEPTH];
  logic             mem_last [RSP_DEPTH];

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQS;
      if (!gnt_any && bus.req_valid[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign grant = reset_n && (state == IDLE) && gnt_any;

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[gnt_id] = 1'b1;
  end

  // sum only grows on issue, so a raised dot_valid never retracts
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count})
                     < (CNT_W+1)'(RSP_DEPTH);
  assign issuing   = (state == ISSUE);
  assign beat_fire = bus.dot_valid && bus.dot_ready;

  always_comb begin
    beat_mask = '0;
    for (int k = 0; k < MAC_UNITS; k++) begin
      beat_mask[k] = ({1'b0, offset} + OFF_W'(k)) < OFF_W'(cur_len);
    end
    beat_last = ({1'b0, offset} + OFF_W'(MAC_UNITS)) >= OFF_W'(cur_len);
  end

  assign bus.dot_valid  = issuing && credit_ok;
  assign bus.dot_id     = issuing ? cur_id : '0;
  assign bus.dot_offset = issuing ? offset[LEN_W-1:0] : '0;
  assign bus.dot_mask   = issuing ? beat_mask : '0;
  assign bus.dot_last   = issuing && beat_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cur_id  <= '0;
      cur_len <= '0;
      offset  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            cur_id  <= gnt_id;
            cur_len <= bus.req_len[gnt_id*LEN_W +: LEN_W];
            offset  <= '0;
            rr_ptr  <= (gnt_id == ID_W'(NUM_REQS-1)) ? '0 : gnt_id + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat_fire) begin
            if (beat_last) state <= IDLE;
            else offset <= offset + (LEN_W+1)'(MAC_UNITS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = bus.dot_rsp_valid;
  assign pop  = bus.rsp_valid && bus.rsp_ready;
  assign full = (fifo_count == CNT_W'(RSP_DEPTH));
  // stale returns after a reset find no credit to give back
  assign dec  = bus.dot_rsp_valid && (inflight != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      unique case ({beat_fire, dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= bus.dot_rsp_data;
        mem_id[wr_ptr]   <= bus.dot_rsp_id;
        mem_last[wr_ptr] <= bus.dot_rsp_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? mem_data[rd_ptr] : '0;
  assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr] : '0;
  assign bus.rsp_last  = bus.rsp_valid && mem_last[rd_ptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n) !(push && full && !pop)
  ) else $error("tensor_dot_sched: response push while full");

`ifdef TENSOR_DOT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_cycles   <= '0;
      perf_credit_stalls <= '0;
    end else begin
      if (issuing && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if (issuing && !credit_ok && perf_credit_stalls != '1)
        perf_credit_stalls <= perf_credit_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_tensor_dot_sched.sv
// Randomized self-checking bench for tensor_dot_sched against a
// job-level reference model (round-robin order, beat expansion, in-order FIFO).
module tb_tensor_dot_sched;
  localparam int NR = 4;
  localparam int MU = 4;
  localparam int LW = 8;
  localparam int RW = 32;
  localparam int RD = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] off;
    logic [3:0] mask;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic        last;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tensor_dot_sched_if #(
    .NUM_REQS(NR), .MAC_UNITS(MU), .LEN_W(LW), .RSP_W(RW)
  ) bus ();

  tensor_dot_sched #(
    .NUM_REQS(NR), .MAC_UNITS(MU), .LEN_W(LW), .RSP_W(RW), .RSP_DEPTH(RD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  beat_t obs_b[$];
  beat_t exp_b[$];
  beat_t pend[$];
  rsp_t  obs_r[$];
  rsp_t  exp_r[$];
  int    obs_g[$];
  int    exp_g[$];

  int jl[NR][64];
  int jh[NR];
  int jt[NR];
  int mptr;
  int dr_pct;
  int ret_pct;
  int rsp_pct;
  int checks;
  int errors;

  // environment: requesters, dot unit (in-order, random latency), writeback
  initial begin
    beat_t b;
    rsp_t  r;
    bus.req_valid     = '0;
    bus.req_len       = '0;
    bus.dot_ready     = 1'b0;
    bus.dot_rsp_valid = 1'b0;
    bus.dot_rsp_data  = '0;
    bus.dot_rsp_id    = '0;
    bus.dot_rsp_last  = 1'b0;
    bus.rsp_ready     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.dot_ready = int'($urandom_range(99)) < dr_pct;
      bus.rsp_ready = int'($urandom_range(99)) < rsp_pct;
      if (reset_n === 1'b1 && pend.size() > 0 &&
          int'($urandom_range(99)) < ret_pct) begin
        b = pend.pop_front();
        r.data = $urandom;
        r.id   = b.id;
        r.last = b.last;
        exp_r.push_back(r);
        bus.dot_rsp_valid = 1'b1;
        bus.dot_rsp_data  = r.data;
        bus.dot_rsp_id    = r.id;
        bus.dot_rsp_last  = r.last;
      end else begin
        bus.dot_rsp_valid = 1'b0;
        bus.dot_rsp_data  = '0;
        bus.dot_rsp_id    = '0;
        bus.dot_rsp_last  = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        bus.req_valid[i] = jh[i] < jt[i];
        bus.req_len[i*LW +: LW] = '0;
        if (jh[i] < jt[i]) bus.req_len[i*LW +: LW] = LW'(jl[i][jh[i]]);
      end
    end
  end

  // monitor: records handshakes that complete at the next rising edge
  initial begin
    beat_t b;
    rsp_t  r;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (bus.dot_valid && bus.dot_ready) begin
          b.id   = bus.dot_id;
          b.off  = bus.dot_offset;
          b.mask = bus.dot_mask;
          b.last = bus.dot_last;
          obs_b.push_back(b);
          pend.push_back(b);
        end
        for (int i = 0; i < NR; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            obs_g.push_back(i);
            jh[i]++;
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          r.data = bus.rsp_data;
          r.id   = bus.rsp_id;
          r.last = bus.rsp_last;
          obs_r.push_back(r);
        end
      end
    end
  end

  task automatic add_job(input int r, input int len);
    jl[r][jt[r]] = len;
    jt[r]++;
  endtask

  // reference: round-robin over pending jobs, each expanded into beats
  task automatic build_expect();
    int h[NR];
    int g, len, n;
    bit found;
    beat_t b;
    for (int i = 0; i < NR; i++) h[i] = jh[i];
    forever begin
      found = 0;
      g = 0;
      for (int i = 0; i < NR; i++) begin
        if (!found && h[(mptr + i) % NR] < jt[(mptr + i) % NR]) begin
          found = 1;
          g = (mptr + i) % NR;
        end
      end
      if (!found) break;
      exp_g.push_back(g);
      len = jl[g][h[g]];
      h[g]++;
      n = (len == 0) ? 1 : (len + MU - 1) / MU;
      for (int k = 0; k < n; k++) begin
        b.id  = 2'(g);
        b.off = 8'(k * MU);
        for (int l = 0; l < MU; l++) b.mask[l] = (k * MU + l) < len;
        b.last = (k == n - 1);
        exp_b.push_back(b);
      end
      mptr = (g + 1) % NR;
    end
  endtask

  task automatic clear_obs();
    obs_b.delete();
    exp_b.delete();
    obs_r.delete();
    exp_r.delete();
    obs_g.delete();
    exp_g.delete();
  endtask

  task automatic clear_env();
    clear_obs();
    pend.delete();
    for (int i = 0; i < NR; i++) begin
      jh[i] = 0;
      jt[i] = 0;
    end
    mptr = 0;
    bus.dot_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_env();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    bit idle;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      idle = pend.size() == 0 && !bus.dot_valid && !bus.rsp_valid &&
             !bus.dot_rsp_valid && obs_r.size() == exp_b.size();
      for (int i = 0; i < NR; i++) if (jh[i] != jt[i]) idle = 0;
      if (idle) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dr_pct = 100; ret_pct = 100; rsp_pct = 100;
    clear_env();
    #2;
    checks++;
    if ({bus.req_ready, bus.dot_valid, bus.dot_mask, bus.dot_last,
         bus.dot_offset, bus.dot_id, bus.rsp_valid, bus.rsp_data,
         bus.rsp_id, bus.rsp_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: outputs not all zero during reset");
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.dot_valid, bus.rsp_valid} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: req_ready/dot_valid/rsp_valid=%b %b %b",
               bus.req_ready, bus.dot_valid, bus.rsp_valid);
    end
  endtask

  task automatic test_single_job();
    bit ok;
    clear_obs();
    dr_pct = 100; ret_pct = 100; rsp_pct = 100;
    add_job(0, 10);
    build_expect();
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: job did not drain"); end
    checks++;
    if (obs_b.size() != 3) begin
      errors++;
      $display("FAIL single_beats: got %0d beats, need 3", obs_b.size());
    end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL single_beat%0d: got %h need %h", i,
                 (i < obs_b.size()) ? obs_b[i] : '0, exp_b[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    dr_pct = 100; ret_pct = 100; rsp_pct = 100;
    for (int r = 0; r < NR; r++) add_job(r, 4);
    add_job(0, 4);
    build_expect();
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout: jobs did not drain"); end
    checks++;
    if (obs_g.size() != 5 || obs_b.size() != 5) begin
      errors++;
      $display("FAIL rr_counts: grants %0d beats %0d, need 5 and 5",
               obs_g.size(), obs_b.size());
    end
    foreach (exp_g[i]) begin
      checks++;
      if (i >= obs_g.size() || obs_g[i] != exp_g[i]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %0d need %0d", i,
                 (i < obs_g.size()) ? obs_g[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    bit ok;
    beat_t need;
    clear_obs();
    dr_pct = 100; ret_pct = 100; rsp_pct = 100;
    add_job(2, 0);
    build_expect();
    wait_done(100, ok);
    need.id = 2'd2; need.off = 8'd0; need.mask = 4'h0; need.last = 1'b1;
    checks++;
    if (!ok || obs_b.size() != 1 || obs_b[0] !== need) begin
      errors++;
      $display("FAIL len0_beat: beats %0d first %h need 1 beat %h",
               obs_b.size(), (obs_b.size() > 0) ? obs_b[0] : '0, need);
    end
    checks++;
    if (obs_r.size() != 1 || exp_r.size() != 1 ||
        obs_r[0] !== exp_r[0] || obs_r[0].last !== 1'b1) begin
      errors++;
      $display("FAIL len0_rsp: rsp count %0d, need 1 with last=1 id=2",
               obs_r.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    dr_pct = 100; ret_pct = 100; rsp_pct = 0;
    add_job(1, 64);
    build_expect();
    repeat (40) @(negedge clk);
    checks++;
    if (obs_b.size() != RD) begin
      errors++;
      $display("FAIL bp_credit_beats: got %0d need %0d", obs_b.size(), RD);
    end
    checks++;
    if (bus.dot_valid !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: dot_valid=%b rsp_valid=%b need 0 1",
               bus.dot_valid, bus.rsp_valid);
    end
    rsp_pct = 100;
    wait_done(400, ok);
    checks++;
    if (!ok || obs_b.size() != 16) begin
      errors++;
      $display("FAIL bp_resume: ok=%0d beats %0d need 16", ok, obs_b.size());
    end
    foreach (exp_r[i]) begin
      checks++;
      if (i >= obs_r.size() || obs_r[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL bp_rsp%0d: got %h need %h", i,
                 (i < obs_r.size()) ? obs_r[i] : '0, exp_r[i]);
      end
    end
  endtask

  task automatic test_dot_ready_toggle();
    bit ok, stall, idle;
    beat_t prev, cur;
    clear_obs();
    dr_pct = 50; ret_pct = 50; rsp_pct = 60;
    add_job(0, 13);
    add_job(3, 30);
    add_job(1, 7);
    build_expect();
    stall = 0;
    ok = 0;
    prev = '0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      cur.id = bus.dot_id; cur.off = bus.dot_offset;
      cur.mask = bus.dot_mask; cur.last = bus.dot_last;
      if (stall) begin
        checks++;
        if (!bus.dot_valid || cur !== prev) begin
          errors++;
          $display("FAIL hold_payload: valid=%b got %h need %h",
                   bus.dot_valid, cur, prev);
        end
      end
      stall = bus.dot_valid && !bus.dot_ready;
      prev = cur;
      idle = pend.size() == 0 && !bus.dot_valid && !bus.rsp_valid &&
             !bus.dot_rsp_valid && obs_r.size() == exp_b.size();
      for (int i = 0; i < NR; i++) if (jh[i] != jt[i]) idle = 0;
      ok = idle;
    end
    checks++;
    if (!ok || obs_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL toggle_count: ok=%0d beats %0d need %0d",
               ok, obs_b.size(), exp_b.size());
    end
    foreach (exp_b[i]) begin
      checks++;
      if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL toggle_beat%0d: got %h need %h", i,
                 (i < obs_b.size()) ? obs_b[i] : '0, exp_b[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int nj;
    for (int rnd = 0; rnd < 6; rnd++) begin
      clear_obs();
      dr_pct  = int'($urandom_range(100, 30));
      ret_pct = int'($urandom_range(100, 30));
      rsp_pct = int'($urandom_range(100, 30));
      nj = int'($urandom_range(6, 1));
      for (int j = 0; j < nj; j++)
        add_job(int'($urandom_range(NR - 1)), int'($urandom_range(40)));
      build_expect();
      wait_done(3000, ok);
      checks++;
      if (!ok || obs_b.size() != exp_b.size() || obs_r.size() != exp_r.size()) begin
        errors++;
        $display("FAIL rand%0d_count: ok=%0d beats %0d/%0d rsps %0d/%0d", rnd,
                 ok, obs_b.size(), exp_b.size(), obs_r.size(), exp_r.size());
      end
      foreach (exp_g[i]) begin
        checks++;
        if (i >= obs_g.size() || obs_g[i] != exp_g[i]) begin
          errors++;
          $display("FAIL rand%0d_grant%0d: got %0d need %0d", rnd, i,
                   (i < obs_g.size()) ? obs_g[i] : -1, exp_g[i]);
        end
      end
      foreach (exp_b[i]) begin
        checks++;
        if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: got %h need %h", rnd, i,
                   (i < obs_b.size()) ? obs_b[i] : '0, exp_b[i]);
        end
      end
      foreach (exp_r[i]) begin
        checks++;
        if (i >= obs_r.size() || obs_r[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL rand%0d_rsp%0d: got %h need %h", rnd, i,
                   (i < obs_r.size()) ? obs_r[i] : '0, exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    do_reset();
    dr_pct = 100; ret_pct = 100; rsp_pct = 100;
    add_job(2, 20);
    build_expect();
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = obs_b.size() >= 2;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_start: beats %0d need 2", obs_b.size()); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.dot_valid, bus.dot_mask, bus.dot_last,
         bus.dot_offset, bus.dot_id, bus.rsp_valid, bus.rsp_data} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: dot_valid=%b mask=%h rsp_valid=%b need 0",
               bus.dot_valid, bus.dot_mask, bus.rsp_valid);
    end
    clear_env();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    add_job(3, 4);
    add_job(1, 4);
    build_expect();
    wait_done(200, ok);
    checks++;
    if (!ok || obs_g.size() != 2 || obs_g[0] != exp_g[0] || obs_g[1] != exp_g[1]) begin
      errors++;
      $display("FAIL midrst_rr: first grant %0d need %0d",
               (obs_g.size() > 0) ? obs_g[0] : -1, exp_g[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      jh[i] = 0;
      jt[i] = 0;
    end
    test_reset();
    test_single_job();
    test_round_robin();
    test_len_zero();
    test_backpressure();
    test_dot_ready_toggle();
    test_random();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
